// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and default baud divisor.
// The receiver's optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    // Even-parity bit that makes the total count of ones (data + parity) even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, one stop bit, mid-bit sampling of the synchronized line.
// Define UART_RX_PARITY_EN to expect one even-parity bit between bit 7 and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    uart_rx_state_t            r_state;
    logic [TW-1:0]             r_timer;
    logic [BW-1:0]             r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_rx_prev;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_busy;
    logic                      w_rx_s;
    logic                      w_tick;
    logic                      w_par_ok;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_tick = (r_timer == '0);

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (r_state == ST_PARITY && w_tick) begin
            r_par_err <= (uart_even_parity(r_shift) != w_rx_s);
        end
    end

    assign w_par_ok = !r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    // Receive FSM; the timer free-runs down to zero and each state acts on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rx_prev   <= 1'b1;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_prev   <= w_rx_s;
            if (!w_tick) begin
                r_timer <= r_timer - TW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_timer <= HALF_LOAD;
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_timer   <= FULL_LOAD;
                            r_bit_cnt <= '0;
                            r_state   <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_timer <= FULL_LOAD;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_timer <= FULL_LOAD;
                        r_state <= ST_STOP;
                    end
                end
`endif

                // Leaving at mid-stop-bit lets a start edge half a bit later be caught.
                ST_STOP: begin
                    if (w_tick) begin
                        if (w_rx_s && w_par_ok) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end
                end

                // A held-low line must return high before another frame can start.
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8; parity cases run when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // pin edge -> rx_s (2) + half bit + stop index bit periods + registered pulse (1)
    localparam int PULSE_LAT = 2 + CPB / 2 + STOP_IDX * CPB + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pulse and checks kind, data and cycle.
    logic [7:0] prev_data = 8'h00;
    bit         prev_pulse = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_data  = data;
            prev_pulse = 1'b0;
        end else begin
            if (valid || frame_err) begin
                if (prev_pulse) chk("pulse_back_to_back", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(frame_err), 32'(valid));
                    chk("unexpected_pulse_present", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_frame_err", 32'(frame_err), 32'(e.is_err));
                    chk("pulse_valid_and_err", 32'(valid & frame_err), 0);
                    chk("pulse_cycle", cyc, e.cyc);
                    if (!e.is_err) chk("valid_data", 32'(data), 32'(e.data));
                end
            end
            if (data !== prev_data && !valid) chk("data_changed_without_valid", 32'(data), 32'(prev_data));
            prev_data  = data;
            prev_pulse = valid || frame_err;
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit bad_par);
        exp_t e;
        e.is_err = !(stop_bit && !bad_par);
        e.data   = d;
        e.cyc    = cyc + PULSE_LAT;
        exp_q.push_back(e);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit((^d) ^ bad_par);
`endif
        hold_bit(stop_bit);
    endtask

    initial begin
        int         st;
        logic [7:0] abort_byte;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data", 32'(data), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // Single good byte
        send_frame(8'h31, 1'b1, 1'b0);
        idle(20);

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        idle(20);

        // Three-cycle low glitch: START is entered then abandoned
        st = cyc;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_in_start", 32'(busy), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("glitch_cycle_ref", cyc - st, 7);
        chk("glitch_busy_cleared", 32'(busy), 0);
        idle(20);

        // Bad stop bit followed by a held-low line
        send_frame(8'h7E, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("break_busy_held", 32'(busy), 1);
        idle(20);
        chk("data_kept_after_frame_err", 32'(data), 32'h0000_00AA);
        chk("busy_idle_after_break", 32'(busy), 0);
        send_frame(8'h0D, 1'b1, 1'b0);
        idle(20);

        // Reset during data bit 4 of 0x41 discards the frame
        abort_byte = 8'h41;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(abort_byte[i]);
        rx = abort_byte[4];
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        chk("midframe_reset_data", 32'(data), 0);
        chk("midframe_reset_valid", 32'(valid), 0);
        chk("midframe_reset_frame_err", 32'(frame_err), 0);
        chk("midframe_reset_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(20);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even ones, so the correct even-parity bit is 0
        send_frame(8'h03, 1'b1, 1'b1);
        idle(20);
        chk("data_kept_after_parity_err", 32'(data), 32'h0000_0042);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(20);
`endif

        idle(40);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
